// File: rtl/vme_pkg.sv
// Shared VME slave definitions: AM codes, FSM states, byte-enable patterns and bus levels.
package vme_pkg;

    localparam logic VmeActive   = 1'b0;
    localparam logic VmeInactive = 1'b1;

    localparam logic [5:0] AmA32NonPrivData = 6'h09;
    localparam logic [5:0] AmA32SupData     = 6'h0D;
    localparam logic [5:0] AmA24NonPrivData = 6'h39;
    localparam logic [5:0] AmA24SupData     = 6'h3D;

    // Bit 3 is byte 0 (big-endian lane order)
    localparam logic [3:0] BeQuad  = 4'b1111;
    localparam logic [3:0] BeHalf0 = 4'b1100;
    localparam logic [3:0] BeHalf1 = 4'b0011;
    localparam logic [3:0] BeByte0 = 4'b1000;
    localparam logic [3:0] BeByte1 = 4'b0100;
    localparam logic [3:0] BeByte2 = 4'b0010;
    localparam logic [3:0] BeByte3 = 4'b0001;

    typedef enum logic [1:0] {StIdle, StAccess, StSetup, StRespond} vme_state_e;

    typedef struct packed {
        logic       legal;
        logic [3:0] be;
    } be_dec_t;

    function automatic logic am_ok(input logic [5:0] am);
        return am inside {AmA32NonPrivData, AmA32SupData, AmA24NonPrivData, AmA24SupData};
    endfunction

    // ds_n[1] is DS1, ds_n[0] is DS0; all inputs active-low except a01
    function automatic be_dec_t decode_be(input logic lword_n, input logic [1:0] ds_n,
                                          input logic a01);
        be_dec_t r;
        r.legal = 1'b1;
        r.be    = 4'b0000;
        case (ds_n)
            2'b00: begin
                if (lword_n == VmeActive) begin
                    r.legal = (a01 == 1'b0);
                    r.be    = BeQuad;
                end else begin
                    r.be = a01 ? BeHalf1 : BeHalf0;
                end
            end
            2'b01: begin
                r.legal = (lword_n == VmeInactive);
                r.be    = a01 ? BeByte2 : BeByte0;
            end
            2'b10: begin
                r.legal = (lword_n == VmeInactive);
                r.be    = a01 ? BeByte3 : BeByte1;
            end
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vme_sync.sv
// Parameterized-width two-flop synchronizer with a configurable asynchronous reset value.
module vme_sync #(
    parameter int unsigned       Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/vme_slave_responder.sv
// VME slave cycle responder bridging one VME access to a local request/ack handshake.
// Optional local-ack timeout (BERR on expiry) enabled by VME_SLAVE_BERR_TIMEOUT_EN.
module vme_slave_responder
    import vme_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR      = 8'h80,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       vme_as_i,
    input  logic [1:0] vme_ds_i,
    input  logic       vme_lword_i,
    input  logic       vme_write_i,
    input  logic [5:0] vme_address_mod_i,
    input  logic [7:0] vme_address_hi_i,
    input  logic       vme_a01_i,
    input  logic       vme_iack_i,
    output logic       vme_dtack_oe_o,
    output logic       vme_berr_oe_o,
    output logic       local_req_o,
    output logic       local_write_o,
    output logic [3:0] local_be_o,
    input  logic       local_ack_i,
    input  logic       local_err_i,
    output logic       data_oe_o,
    output logic       data_dir_o
);

    logic [3:0] sync_out;
    logic       as_s;
    logic [1:0] ds_s;
    logic       iack_s;

    vme_sync #(
        .Width    (4),
        .ResetVal ({4{VmeInactive}})
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({vme_iack_i, vme_ds_i, vme_as_i}),
        .q_o    (sync_out)
    );

    assign as_s   = sync_out[0];
    assign ds_s   = sync_out[2:1];
    assign iack_s = sync_out[3];

    vme_state_e state_q;
    logic       armed_q;
    logic [1:0] settle_q;
    logic       illegal_q;
    logic       dtack_q, berr_q, req_q, write_q, data_oe_q, data_dir_q;
    logic [3:0] be_q;
    logic       timeout;
    logic       hit;
    be_dec_t    dec;

`ifdef VME_SLAVE_BERR_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q == StAccess) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign timeout = (state_q == StAccess) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    assign dec = decode_be(vme_lword_i, ds_s, vme_a01_i);
    assign hit = armed_q && (as_s == VmeActive) && (ds_s != {2{VmeInactive}})
                 && (iack_s == VmeInactive) && am_ok(vme_address_mod_i)
                 && (vme_address_hi_i == BASE_ADDR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            armed_q    <= 1'b0;
            settle_q   <= 2'b00;
            illegal_q  <= 1'b0;
            dtack_q    <= 1'b0;
            berr_q     <= 1'b0;
            req_q      <= 1'b0;
            write_q    <= 1'b0;
            be_q       <= 4'b0000;
            data_oe_q  <= 1'b0;
            data_dir_q <= 1'b0;
        end else begin
            // The synchronizer's reset value is not a real observation of AS high
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && (as_s == VmeInactive)) begin
                armed_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        state_q   <= StAccess;
                        armed_q   <= 1'b0;
                        illegal_q <= !dec.legal;
                        if (dec.legal) begin
                            req_q      <= 1'b1;
                            write_q    <= (vme_write_i == VmeActive);
                            be_q       <= dec.be;
                            data_oe_q  <= 1'b1;
                            data_dir_q <= vme_write_i;
                        end
                    end
                end
                StAccess: begin
                    if (illegal_q || local_err_i || timeout) begin
                        state_q   <= StRespond;
                        berr_q    <= 1'b1;
                        req_q     <= 1'b0;
                        data_oe_q <= 1'b0;
                    end else if (local_ack_i) begin
                        state_q <= StSetup;
                        req_q   <= 1'b0;
                    end
                end
                StSetup: begin
                    state_q <= StRespond;
                    dtack_q <= 1'b1;
                end
                StRespond: begin
                    if (ds_s == {2{VmeInactive}}) begin
                        state_q    <= StIdle;
                        illegal_q  <= 1'b0;
                        dtack_q    <= 1'b0;
                        berr_q     <= 1'b0;
                        write_q    <= 1'b0;
                        be_q       <= 4'b0000;
                        data_oe_q  <= 1'b0;
                        data_dir_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign vme_dtack_oe_o = dtack_q;
    assign vme_berr_oe_o  = berr_q;
    assign local_req_o    = req_q;
    assign local_write_o  = write_q;
    assign local_be_o     = be_q;
    assign data_oe_o      = data_oe_q;
    assign data_dir_o     = data_dir_q;

endmodule
